// File: rtl/cpu_multicycle_if.sv
// Instruction-memory port of cpu_multicycle: word address and request from the
// core, instruction word and valid strobe back from the memory.
interface cpu_multicycle_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic [31:0]     imem_data;
    logic            imem_valid;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_data,
        input  imem_valid
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_data,
        output imem_valid
    );
endinterface

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: FETCH/DECODE/EXEC/WB sequenced core with a 32-entry register
// file, R-type ALU ops, ADDI/ANDI/ORI, BEQ and HALT. One instruction takes at
// least four cycles plus any cycles the instruction memory holds valid low.
// Optional build macro CPU_MC_SHIFT_EN enables the SLL/SRL/SRA R-type funcs;
// without it those funcs decode as unknown and execute as a NOP.
module cpu_multicycle #(
    parameter int              DATA_W = 32,
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_multicycle_if.master  imem,
    output logic [DATA_W-1:0] alu_out,
    output logic              alu_of,
    output logic              alu_zf,
    output logic              reg_we,
    output logic              halted,
    output logic [PC_W-1:0]   dbg_pc,
    output logic [31:0]       dbg_inst
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;

`ifdef CPU_MC_SHIFT_EN
    localparam logic SHIFT_EN = 1'b1;
`else
    localparam logic SHIFT_EN = 1'b0;
`endif

    localparam int MSB = DATA_W - 1;

    state_t            state, state_next;
    logic [PC_W-1:0]   pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] regs [32];

    // Instruction fields and immediates, decoded straight from the IR.
    logic [5:0]        op, func;
    logic [4:0]        rs, rt, rd, shamt;
    logic [DATA_W-1:0] simm, zimm;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign func  = ir[5:0];
    assign simm  = DATA_W'($signed(ir[15:0]));
    assign zimm  = DATA_W'(ir[15:0]);

    logic [DATA_W-1:0] f;
    logic              f_of, known, wr_en, is_beq, is_halt;
    logic [4:0]        dest;

    // ALU and instruction classification; operands come from the A/B latches.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        f       = '0;
        f_of    = 1'b0;
        known   = 1'b0;
        wr_en   = 1'b0;
        is_beq  = 1'b0;
        is_halt = 1'b0;
        dest    = rd;
        case (op)
            OP_RTYPE: begin
                known = 1'b1;
                wr_en = 1'b1;
                case (func)
                    FN_ADD: begin
                        f    = op_a + op_b;
                        f_of = (op_a[MSB] == op_b[MSB]) && (f[MSB] != op_a[MSB]);
                    end
                    FN_SUB: begin
                        f    = op_a - op_b;
                        f_of = (op_a[MSB] != op_b[MSB]) && (f[MSB] != op_a[MSB]);
                    end
                    FN_AND:  f = op_a & op_b;
                    FN_OR:   f = op_a | op_b;
                    FN_XOR:  f = op_a ^ op_b;
                    FN_NOR:  f = ~(op_a | op_b);
                    FN_SLTU: f = DATA_W'(op_a < op_b);
                    FN_SLL, FN_SRL, FN_SRA: begin
                        if (SHIFT_EN) begin
                            if (func == FN_SLL)      f = op_b << shamt;
                            else if (func == FN_SRL) f = op_b >> shamt;
                            else                     f = DATA_W'($signed(op_b) >>> shamt);
                        end else begin
                            known = 1'b0;
                            wr_en = 1'b0;
                        end
                    end
                    default: begin
                        known = 1'b0;
                        wr_en = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                known = 1'b1;
                wr_en = 1'b1;
                dest  = rt;
                f     = op_a + simm;
                f_of  = (op_a[MSB] == simm[MSB]) && (f[MSB] != op_a[MSB]);
            end
            OP_ANDI: begin
                known = 1'b1;
                wr_en = 1'b1;
                dest  = rt;
                f     = op_a & zimm;
            end
            OP_ORI: begin
                known = 1'b1;
                wr_en = 1'b1;
                dest  = rt;
                f     = op_a | zimm;
            end
            OP_BEQ: begin
                known  = 1'b1;
                is_beq = 1'b1;
                f      = op_a - op_b;
                f_of   = (op_a[MSB] != op_b[MSB]) && (f[MSB] != op_a[MSB]);
            end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all sequential state uses <= so every flop samples pre-edge values regardless of block order.
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    // Next-state sequencing; HALT is left only through reset.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (imem.imem_valid) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = is_halt ? S_HALT : S_WB;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Datapath registers: IR capture, operand latches, flags and PC update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RST_PC;
            ir      <= '0;
            op_a    <= '0;
            op_b    <= '0;
            alu_out <= '0;
            alu_of  <= 1'b0;
            alu_zf  <= 1'b0;
        end else begin
            case (state)
                S_FETCH:  if (imem.imem_valid) ir <= imem.imem_data;
                S_DECODE: begin
                    op_a <= regs[rs];
                    op_b <= regs[rt];
                end
                S_EXEC: if (known) begin
                    alu_out <= f;
                    alu_zf  <= (f == '0);
                    alu_of  <= f_of;
                end
                S_WB: pc <= (is_beq && alu_zf) ? pc + PC_W'(1) + simm[PC_W-1:0]
                                               : pc + PC_W'(1);
                default: ;
            endcase
        end
    end

    // Register file write port; r0 is never written, so it always reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file must come up cleared, so it is reset explicitly and maps to flops, not a RAM.
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[dest] <= alu_out;
        end
    end

    assign reg_we         = (state == S_WB) && wr_en && (dest != 5'd0);
    assign halted         = (state == S_HALT);
    assign imem.imem_req  = (state == S_FETCH) && rst_n;
    assign imem.imem_addr = pc;
    assign dbg_pc         = pc;
    assign dbg_inst       = ir;
endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle: directed sequences plus randomized
// instruction streams with random memory stalls, compared against an
// instruction-level reference model of the architectural state.
module tb_cpu_multicycle;
    localparam int DATA_W = 32;
    localparam int PC_W   = 8;

`ifdef CPU_MC_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_multicycle_if #(.PC_W(PC_W)) imem ();

    logic [DATA_W-1:0] alu_out;
    logic              alu_of, alu_zf, reg_we, halted;
    logic [PC_W-1:0]   dbg_pc;
    logic [31:0]       dbg_inst;

    cpu_multicycle #(.DATA_W(DATA_W), .PC_W(PC_W), .RST_PC(8'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .imem     (imem),
        .alu_out  (alu_out),
        .alu_of   (alu_of),
        .alu_zf   (alu_zf),
        .reg_we   (reg_we),
        .halted   (halted),
        .dbg_pc   (dbg_pc),
        .dbg_inst (dbg_inst)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural state only.
    logic [31:0] m_reg [32];
    int          m_pc;
    logic [31:0] m_ir, m_out;
    bit          m_of, m_zf, m_halt, m_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (model pc %0d, t=%0t)", tag, got, exp, m_pc, $time);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [5:0] fn, input int rd, input int rs, input int rt, input int sh);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_pc = 0; m_ir = '0; m_out = '0;
        m_of = 0; m_zf = 0; m_halt = 0; m_we = 0;
    endtask

    // Executes one instruction on the architectural model.
    task automatic model_step(input logic [31:0] w);
        logic [5:0]  op, fn;
        int          rs, rt, rd, sh, dst, simm;
        logic [31:0] a, b, res;
        longint      wide;
        bit          known, wr, of, taken;
        op = w[31:26]; rs = int'(w[25:21]); rt = int'(w[20:16]);
        rd = int'(w[15:11]); sh = int'(w[10:6]); fn = w[5:0];
        simm = int'($signed(w[15:0]));
        a = m_reg[rs]; b = m_reg[rt];
        known = 1; wr = 1; of = 0; taken = 0; dst = rd; res = '0; wide = 0;
        case (op)
            6'h00: case (fn)
                6'h20: begin
                    res = a + b;
                    wide = longint'($signed(a)) + longint'($signed(b));
                    of = (wide != longint'($signed(res)));
                end
                6'h22: begin
                    res = a - b;
                    wide = longint'($signed(a)) - longint'($signed(b));
                    of = (wide != longint'($signed(res)));
                end
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h26: res = a ^ b;
                6'h27: res = ~(a | b);
                6'h2b: res = (a < b) ? 32'd1 : 32'd0;
                6'h00: if (SHIFT_EN) res = b << sh; else known = 0;
                6'h02: if (SHIFT_EN) res = b >> sh; else known = 0;
                6'h03: if (SHIFT_EN) res = 32'($signed(b) >>> sh); else known = 0;
                default: known = 0;
            endcase
            6'h08: begin
                dst = rt;
                res = a + 32'(simm);
                wide = longint'($signed(a)) + longint'(simm);
                of = (wide != longint'($signed(res)));
            end
            6'h0c: begin dst = rt; res = a & {16'h0, w[15:0]}; end
            6'h0d: begin dst = rt; res = a | {16'h0, w[15:0]}; end
            6'h04: begin
                wr = 0;
                res = a - b;
                wide = longint'($signed(a)) - longint'($signed(b));
                of = (wide != longint'($signed(res)));
                taken = (a == b);
            end
            6'h3f: begin known = 0; m_halt = 1; end
            default: known = 0;
        endcase
        m_we = known && wr && (dst != 0);
        if (known) begin
            m_out = res; m_zf = (res == 0); m_of = of;
        end
        if (m_we) m_reg[dst] = res;
        if (!m_halt) begin
            if (taken) m_pc = (((m_pc + 1 + simm) % 256) + 256) % 256;
            else       m_pc = (m_pc + 1) % 256;
        end
    endtask

    task automatic check_reset_values();
        check("rst_req",     32'(imem.imem_req), 32'd0);
        check("rst_halted",  32'(halted),        32'd0);
        check("rst_reg_we",  32'(reg_we),        32'd0);
        check("rst_alu_out", alu_out,            32'd0);
        check("rst_alu_of",  32'(alu_of),        32'd0);
        check("rst_alu_zf",  32'(alu_zf),        32'd0);
        check("rst_pc",      32'(dbg_pc),        32'd0);
        check("rst_inst",    dbg_inst,           32'd0);
    endtask

    // Asserts reset at the current (off-edge) time and releases it a cycle later.
    task automatic do_reset();
        rst_n = 1'b0;
        imem.imem_valid = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1 check("rel_req", 32'(imem.imem_req), 32'd1);
    endtask

    // Feeds one instruction while the core is in FETCH and checks each phase.
    task automatic exec_instr(input logic [31:0] w, input int stall, input bit abort);
        check("fetch_req",  32'(imem.imem_req),  32'd1);
        check("fetch_addr", 32'(imem.imem_addr), 32'(m_pc));
        imem.imem_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            imem.imem_data = $urandom();
            @(negedge clk);
            check("stall_req",  32'(imem.imem_req),  32'd1);
            check("stall_addr", 32'(imem.imem_addr), 32'(m_pc));
            check("stall_inst", dbg_inst,            m_ir);
        end
        imem.imem_data  = w;
        imem.imem_valid = 1'b1;
        @(negedge clk);
        imem.imem_data  = $urandom();
        imem.imem_valid = 1'($urandom_range(0, 1));
        m_ir = w;
        check("ir",         dbg_inst,           w);
        check("decode_req", 32'(imem.imem_req), 32'd0);
        model_step(w);
        @(negedge clk);
        check("exec_we", 32'(reg_we), 32'd0);
        if (abort) begin
            do_reset();
            return;
        end
        @(negedge clk);
        if (m_halt) begin
            check("halt_flag", 32'(halted),        32'd1);
            check("halt_req",  32'(imem.imem_req), 32'd0);
            check("halt_we",   32'(reg_we),        32'd0);
        end else begin
            check("wb_we",     32'(reg_we), 32'(m_we));
            check("wb_halted", 32'(halted), 32'd0);
        end
        check("alu_out", alu_out,     m_out);
        check("alu_of",  32'(alu_of), 32'(m_of));
        check("alu_zf",  32'(alu_zf), 32'(m_zf));
        @(negedge clk);
        imem.imem_valid = 1'b0;
        check("next_pc", 32'(dbg_pc), 32'(m_pc));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [7];
        int k, imm;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2b};
        k = $urandom_range(0, 12);
        case ($urandom_range(0, 4))
            0:       imm = 16'h7fff;
            1:       imm = 16'h8000;
            2:       imm = 16'hffff;
            default: imm = int'($urandom_range(0, 16'hffff));
        endcase
        case (k)
            0, 1, 2, 3, 4: return r_type(fns[$urandom_range(0, 6)], $urandom_range(0, 7),
                                         $urandom_range(0, 7), $urandom_range(0, 7), 0);
            5:  return i_type(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), imm);
            6:  return i_type(6'h0c, $urandom_range(0, 7), $urandom_range(0, 7), imm);
            7:  return i_type(6'h0d, $urandom_range(0, 7), $urandom_range(0, 7), imm);
            8:  return i_type(6'h04, $urandom_range(0, 3), $urandom_range(0, 3),
                              int'($urandom_range(0, 12)) - 6);
            9:  return r_type(($urandom_range(0, 2) == 0) ? 6'h00 :
                              (($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03),
                              $urandom_range(1, 7), 0, $urandom_range(0, 7), $urandom_range(0, 31));
            10: return i_type(6'h15, $urandom_range(0, 7), $urandom_range(0, 7), imm);
            11: return r_type(6'h38, $urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
            default: return i_type(6'h08, $urandom_range(1, 7), 0, imm);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        imem.imem_valid = 1'b0;
        imem.imem_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // BEQ r0,r0,-1 at PC 0 keeps looping on PC 0.
        exec_instr(i_type(6'h04, 0, 0, -1), 0, 0);
        check("beq_loop_pc", 32'(dbg_pc), 32'd0);
        exec_instr(i_type(6'h04, 0, 0, -1), 1, 0);
        check("beq_loop_pc2", 32'(dbg_pc), 32'd0);

        // Basic program: four cycles per instruction with no stalls.
        do_reset();
        t0 = cyc;
        exec_instr(i_type(6'h08, 1, 0, 5), 0, 0);
        exec_instr(i_type(6'h08, 2, 0, 7), 0, 0);
        exec_instr(r_type(6'h20, 3, 1, 2, 0), 0, 0);
        check("prog_cycles", 32'(cyc - t0), 32'd12);
        check("prog_pc",     32'(dbg_pc),   32'd3);
        check("prog_sum",    alu_out,       32'd12);

        // Overflow boundaries: build 0x80000000 and 0x7FFFFFFF.
        exec_instr(i_type(6'h08, 6, 0, 16'h7fff), 0, 0);
        exec_instr(i_type(6'h08, 2, 0, 16'h8000), 0, 0);
        for (int i = 0; i < 16; i++) exec_instr(r_type(6'h20, 2, 2, 2, 0), 0, 0);
        check("build_min", alu_out, 32'h8000_0000);
        exec_instr(r_type(6'h27, 3, 2, 0, 0), 0, 0);
        exec_instr(i_type(6'h08, 1, 0, 1), 0, 0);
        exec_instr(r_type(6'h20, 4, 3, 1, 0), 0, 0);
        check("add_ovf_out", alu_out,     32'h8000_0000);
        check("add_ovf_of",  32'(alu_of), 32'd1);
        exec_instr(r_type(6'h22, 4, 1, 1, 0), 0, 0);
        check("sub_zero_out", alu_out,     32'd0);
        check("sub_zero_zf",  32'(alu_zf), 32'd1);
        check("sub_zero_of",  32'(alu_of), 32'd0);
        exec_instr(r_type(6'h22, 5, 2, 1, 0), 0, 0);

        // BEQ not taken, then taken, then backwards across 0.
        t0 = m_pc;
        exec_instr(i_type(6'h04, 2, 1, 3), 0, 0);
        check("beq_nt_pc", 32'(dbg_pc), 32'((t0 + 1) % 256));
        exec_instr(i_type(6'h04, 1, 1, 3), 0, 0);
        exec_instr(i_type(6'h04, 0, 0, -40), 0, 0);

        // Five stall cycles in FETCH.
        exec_instr(r_type(6'h25, 7, 1, 6, 0), 5, 0);

        // Writes to r0 are dropped; r0 reads 0.
        exec_instr(r_type(6'h20, 0, 1, 2, 0), 0, 0);
        check("r0_we", 32'(reg_we), 32'd0);
        exec_instr(r_type(6'h20, 7, 0, 0, 0), 0, 0);
        check("r0_read", alu_out, 32'd0);

        // Shifts of 0x80000000 held in r2.
        exec_instr(i_type(6'h08, 7, 0, 16'h1234), 0, 0);
        exec_instr(r_type(6'h03, 7, 0, 2, 4), 0, 0);
        exec_instr(r_type(6'h20, 8, 7, 0, 0), 0, 0);
        check("sra_result", alu_out, SHIFT_EN ? 32'hF800_0000 : 32'h0000_1234);
        exec_instr(r_type(6'h02, 9, 0, 2, 4), 0, 0);
        exec_instr(r_type(6'h20, 10, 9, 0, 0), 0, 0);

        // Randomized instruction stream with random stalls.
        for (int n = 0; n < 300; n++) begin
            int st;
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            exec_instr(rand_instr(), st, 0);
        end

        // HALT freezes the core until reset.
        exec_instr(32'hFC00_0000, 0, 0);
        imem.imem_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            imem.imem_data = $urandom();
            @(negedge clk);
            check("frz_halted", 32'(halted),        32'd1);
            check("frz_req",    32'(imem.imem_req), 32'd0);
            check("frz_we",     32'(reg_we),        32'd0);
            check("frz_out",    alu_out,            m_out);
            check("frz_pc",     32'(dbg_pc),        32'(m_pc));
        end

        // Reset during EXEC aborts the instruction; refetch from 0.
        do_reset();
        exec_instr(i_type(6'h08, 1, 0, 5), 0, 0);
        exec_instr(i_type(6'h08, 1, 0, 99), 0, 1);
        exec_instr(r_type(6'h20, 2, 1, 0, 0), 0, 0);
        check("abort_no_write", alu_out, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
